// File: rtl/sample_window_shiftreg.sv
// Sliding window of the last DEPTH samples, newest in slot 0, with optional
// decimation, freeze, synchronous clear, fill tracking and indexed tap readout.
module sample_window_shiftreg #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 51,
   parameter int DECIM = 1,
   parameter int IDX_W = $clog2(DEPTH),
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   freeze,
   input  logic [IDX_W-1:0]       tap_idx,
   output logic [DEPTH*WIDTH-1:0] window,
   output logic [WIDTH-1:0]       tap_data,
   output logic [CNT_W-1:0]       fill_count,
   output logic                   window_full,
   output logic                   out_valid
);

   localparam int DC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DECIM - 1);
   localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH);
   localparam logic [IDX_W:0]   TAP_LIM  = (IDX_W + 1)'(DEPTH);

   logic [WIDTH-1:0] slot_q [DEPTH];
   logic [DC_W-1:0]  dc_q, dc_d;
   logic [CNT_W-1:0] fill_q, fill_d;
   logic             ov_q, ov_d;
   logic             accept;

   // A candidate sample only counts towards decimation when not frozen.
   always_comb begin
      accept = 1'b0;
      dc_d   = dc_q;
      if (in_valid && !freeze) begin
         if (dc_q == DC_LAST) begin
            accept = 1'b1;
            dc_d   = '0;
         end else begin
            dc_d = dc_q + DC_W'(1);
         end
      end
   end

   always_comb begin
      fill_d = fill_q;
      if (accept && (fill_q != FILL_MAX)) begin
         fill_d = fill_q + CNT_W'(1);
      end
      ov_d = accept && (fill_d == FILL_MAX);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dc_q   <= '0;
         fill_q <= '0;
         ov_q   <= 1'b0;
      end else if (clear) begin
         dc_q   <= '0;
         fill_q <= '0;
         ov_q   <= 1'b0;
      end else begin
         dc_q   <= dc_d;
         fill_q <= fill_d;
         ov_q   <= ov_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         logic [WIDTH-1:0] slot_d;

         if (gi == 0) begin : g_head
            assign slot_d = in_data;
         end else begin : g_body
            assign slot_d = slot_q[gi-1];
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               slot_q[gi] <= '0;
            end else if (clear) begin
               slot_q[gi] <= '0;
            end else if (accept) begin
               slot_q[gi] <= slot_d;
            end
         end

         assign window[gi*WIDTH +: WIDTH] = slot_q[gi];
      end
   endgenerate

   // Indices past the last slot exist when DEPTH is not a power of two.
   always_comb begin
      tap_data = '0;
      if ({1'b0, tap_idx} < TAP_LIM) begin
         tap_data = slot_q[tap_idx];
      end
   end

   assign fill_count  = fill_q;
   assign window_full = (fill_q == FILL_MAX);
   assign out_valid   = ov_q;

endmodule

// File: doc/sample_window_shiftreg.md
Name: sample_window_shiftreg

Overview:
- Parametrised successor to the 1-bit, 51-deep serial-input history register.
- Holds the last DEPTH samples of WIDTH bits each, newest in slot 0.
- Adds: valid-qualified input, decimation, freeze, synchronous clear, fill tracking, a full-window strobe, and indexed tap readout.
- Sits between the sample source (comparator/ADC front end) and the downstream correlation/pitch logic, which consumes the whole window or single taps.

Parameters:
- WIDTH, 1, bits per sample (>=1).
- DEPTH, 51, number of samples in the window (>=2).
- DECIM, 1, accept every DECIM-th valid sample (>=1; 1 = no decimation).
- IDX_W, $clog2(DEPTH), tap index width (derived; do not override).
- CNT_W, $clog2(DEPTH+1), fill counter width (derived).

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- clear  in  1  synchronous clear; same effect as reset, applied on the clock edge.
- in_valid  in  1  in_data is a candidate sample this cycle.
- in_data  in  WIDTH  sample value.
- freeze  in  1  hold all state; input is ignored.
- tap_idx  in  IDX_W  slot to read (0 = newest).
- window  out  DEPTH*WIDTH  slot k occupies bits [k*WIDTH +: WIDTH]; registered.
- tap_data  out  WIDTH  slot tap_idx of window; combinational from registers.
- fill_count  out  CNT_W  samples loaded since reset/clear; saturates at DEPTH.
- window_full  out  1  fill_count == DEPTH.
- out_valid  out  1  one-cycle pulse: window updated while full.

Behaviour:
- Reset (async) and clear (sync) zero the following: window, fill_count, decim counter, out_valid.
- Priority on each edge: reset > clear > freeze > normal operation.
- Decim counter dc (0..DECIM-1). On a cycle with in_valid=1 and freeze=0:
  - if dc == DECIM-1, the sample is accepted and dc <= 0;
  - otherwise dc <= dc+1 and the sample is dropped.
- With DECIM=1, every valid sample is accepted; dc stays 0.
- On accept:
  - window <= {window[(DEPTH-1)*WIDTH-1:0], in_data}, i.e. each slot k moves to slot k+1, the oldest slot (DEPTH-1) is discarded, and in_data enters slot 0. Latency is 1 clock.
  - fill_count <= min(fill_count+1, DEPTH).
  - out_valid <= 1 if the post-update fill_count == DEPTH, else 0.
- No accept in a cycle:
  - window and fill_count hold;
  - out_valid <= 0, so the pulse is exactly one cycle wide.
- freeze=1: all registers hold, including dc. An in_valid during freeze is lost and does not advance dc. out_valid <= 0.
- window_full: combinational compare of fill_count; stays 1 until clear or reset.
- tap_data:
  - window slot tap_idx;
  - if tap_idx >= DEPTH (possible when DEPTH is not a power of 2), tap_data = 0;
  - reflects the new window in the same cycle the register updates.
- Back-to-back accepts at full rate are supported (one per clock when DECIM=1). out_valid stays high on consecutive accepts once full.
- clear asserted together with in_valid: clear wins and the sample is dropped.
- Reset mid-fill: fill_count returns to 0, and window_full/out_valid drop immediately (async).
- Compatibility: WIDTH=1, DEPTH=51, DECIM=1 with freeze=0 and clear=0 must give the same window as the previous generation, where in_valid plays the ready role.

Test Plan:
- Reset/idle: assert reset mid-cycle -> window=0, fill_count=0, window_full=0, out_valid=0 immediately, without waiting for a clk edge.
- Fill, defaults (WIDTH=1, DEPTH=51): drive in_valid=1 with data 1,0,1,1,... for 51 cycles -> fill_count steps 1..51; window_full rises after the 51st accept; out_valid pulses first on that cycle; window[0] = last bit, window[50] = first bit. A 52nd sample leaves fill_count=51, shifts out the first bit, and pulses out_valid.
- Multi-bit + taps (WIDTH=8, DEPTH=5): push 0x11,0x22,0x33,0x44,0x55,0x66 -> window slots 0..4 = 0x66,0x55,0x44,0x33,0x22; tap_idx=3 gives 0x33; tap_idx=6 gives 0x00.
- Decimation (DECIM=3, WIDTH=8): valid samples 1..9 -> only 3, 6, 9 accepted; fill_count=3; slot0=9, slot1=6, slot2=3. Gaps in in_valid do not advance dc.
- Freeze/clear priority: while full, set freeze=1 with in_valid=1 for 4 cycles -> window unchanged, out_valid=0. Then clear=1 with in_valid=1 in the same cycle -> next cycle window=0, fill_count=0, and the sample is not loaded.
- Back-to-back after clear: clear, then DEPTH consecutive accepts -> out_valid low for DEPTH-1 cycles, high on the DEPTH-th and on every further consecutive accept.
